// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_sync_decoder : monochrome VGA receiver - coordinate recovery, timing check, lock
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 24,
  parameter int   H_SYNC      = 40,
  parameter int   H_BP        = 128,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 9,
  parameter int   V_SYNC      = 3,
  parameter int   V_BP        = 28,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic       video_clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pixel_in,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       pixel_out,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_count
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
  localparam logic [9:0] c_h_act_lo = 10'(H_SYNC + H_BP);
  localparam logic [9:0] c_h_act_hi = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] c_v_act_lo = 10'(V_SYNC + V_BP);
  localparam logic [9:0] c_v_act_hi = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam int c_wd_w   = $clog2(2 * c_h_total + 1);
  localparam logic [c_wd_w-1:0] c_wd_one = c_wd_w'(1);
  localparam logic [c_wd_w-1:0] c_los_cnt = c_wd_w'(2 * c_h_total);
  localparam logic [c_wd_w-1:0] c_los_pre = c_wd_w'(2 * c_h_total - 1);
  localparam int c_good_w = $clog2(LOCK_FRAMES + 1);
  localparam logic [c_good_w-1:0] c_good_one   = c_good_w'(1);
  localparam logic [c_good_w-1:0] c_lock_frames = c_good_w'(LOCK_FRAMES);
  localparam logic c_sync_idle = ~SYNC_POL;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  logic [1:0]        r_hs_sync, r_vs_sync, r_px_sync;
  logic              r_hs_prev, r_vs_prev;
  logic              w_hs_act, w_vs_act, w_hs_edge, w_vs_edge;
  logic [9:0]        r_hcnt, r_vcnt, w_hcnt_nxt, w_vcnt_nxt;
  logic [c_wd_w-1:0] r_wd, w_wd_nxt;
  logic              r_vs_pending, r_first_done, r_err_seen;
  logic              w_boundary, w_h_err, w_v_err, w_los_err, w_any_err;
  logic              w_h_win, w_v_win, w_valid_nxt;
  state_t            r_state, w_state_nxt;
  logic [c_good_w-1:0] r_good, w_good_nxt;

  assign w_hs_act  = (r_hs_sync[1] == SYNC_POL);
  assign w_vs_act  = (r_vs_sync[1] == SYNC_POL);
  assign w_hs_edge = w_hs_act & ~r_hs_prev;
  assign w_vs_edge = w_vs_act & ~r_vs_prev;

  always_ff @(posedge video_clk) begin
    if (reset) begin
      r_hs_sync <= {2{c_sync_idle}};
      r_vs_sync <= {2{c_sync_idle}};
      r_px_sync <= 2'b00;
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_hs_sync <= {r_hs_sync[0], hsync_in};
      r_vs_sync <= {r_vs_sync[0], vsync_in};
      r_px_sync <= {r_px_sync[0], pixel_in};
      r_hs_prev <= w_hs_act;
      r_vs_prev <= w_vs_act;
    end
  end

  assign w_boundary = w_hs_edge & (r_vs_pending | w_vs_edge);
  assign w_h_err    = w_hs_edge & (r_hcnt != c_h_last);
  assign w_v_err    = w_boundary & r_first_done & (r_vcnt != c_v_last);
  assign w_los_err  = ~w_hs_edge & (r_wd == c_los_pre);
  assign w_any_err  = w_h_err | w_v_err | w_los_err;

  assign w_hcnt_nxt = w_hs_edge ? 10'd0 : r_hcnt + 10'd1;
  assign w_vcnt_nxt = w_boundary ? 10'd0 : (w_hs_edge ? r_vcnt + 10'd1 : r_vcnt);
  // Watchdog parks at the loss threshold so a single outage reports once
  assign w_wd_nxt   = w_hs_edge ? '0 : ((r_wd == c_los_cnt) ? r_wd : r_wd + c_wd_one);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_boundary) begin
          w_state_nxt = ST_ACQUIRE;
          w_good_nxt  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (w_los_err) begin
          w_state_nxt = ST_UNLOCKED;
          w_good_nxt  = '0;
        end else if (w_boundary) begin
          if (r_err_seen | w_any_err) begin
            w_good_nxt = '0;
          end else if (r_good + c_good_one == c_lock_frames) begin
            w_state_nxt = ST_LOCKED;
            w_good_nxt  = '0;
          end else begin
            w_good_nxt = r_good + c_good_one;
          end
        end
      end
      ST_LOCKED: begin
        if (w_any_err) w_state_nxt = ST_UNLOCKED;
      end
      default: w_state_nxt = ST_UNLOCKED;
    endcase
  end

  // Window decode uses next-state counters so the registered coordinates
  // line up with the pixel leaving the synchronizer in the same cycle.
  assign w_h_win     = (w_hcnt_nxt >= c_h_act_lo) && (w_hcnt_nxt <= c_h_act_hi);
  assign w_v_win     = (w_vcnt_nxt >= c_v_act_lo) && (w_vcnt_nxt <= c_v_act_hi);
  assign w_valid_nxt = (w_state_nxt == ST_LOCKED) && w_h_win && w_v_win;

  always_ff @(posedge video_clk) begin
    if (reset) begin
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_wd         <= '0;
      r_vs_pending <= 1'b0;
      r_first_done <= 1'b0;
      r_err_seen   <= 1'b0;
      r_state      <= ST_UNLOCKED;
      r_good       <= '0;
      err_count    <= 8'd0;
      x_pos        <= 10'd0;
      y_pos        <= 10'd0;
      pixel_out    <= 1'b0;
      pixel_valid  <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      r_hcnt       <= w_hcnt_nxt;
      r_vcnt       <= w_vcnt_nxt;
      r_wd         <= w_wd_nxt;
      r_vs_pending <= w_boundary ? 1'b0 : (r_vs_pending | w_vs_edge);
      r_first_done <= r_first_done | w_boundary;
      r_err_seen   <= (w_boundary || r_state == ST_UNLOCKED) ? 1'b0 : (r_err_seen | w_any_err);
      r_state      <= w_state_nxt;
      r_good       <= w_good_nxt;
      if (w_any_err && r_state != ST_UNLOCKED && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      x_pos        <= w_valid_nxt ? w_hcnt_nxt - c_h_act_lo : 10'd0;
      y_pos        <= w_valid_nxt ? w_vcnt_nxt - c_v_act_lo : 10'd0;
      pixel_out    <= r_px_sync[1];
      pixel_valid  <= w_valid_nxt;
      frame_start  <= w_boundary && (w_state_nxt == ST_LOCKED);
    end
  end

  assign locked = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vga_sync_decoder : directed checks of lock, placement and error handling on a reduced raster
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int H_ACT = 64, H_FP = 8, H_SYN = 8, H_BP = 16, H_TOT = 96;
  localparam int V_ACT = 12, V_FP = 2, V_SYN = 2, V_BP = 4, V_TOT = 20;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int HS = H_SYN + H_BP;
  localparam int VS = V_SYN + V_BP;

  logic       video_clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       pixel_in = 1'b0;
  logic [9:0] x_pos, y_pos;
  logic       pixel_out, pixel_valid, frame_start, locked;
  logic [7:0] err_count;

  int total = 0;
  int bad = 0;
  int gh = 0, gv = 0, short_v = -1, frame_len = V_TOT;
  bit idle = 1'b1, hold_h = 1'b0, pix_en = 1'b0;

  always #5 video_clk = ~video_clk;

  vga_sync_decoder #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYN), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .video_clk(video_clk), .reset(reset),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_in(pixel_in),
    .x_pos(x_pos), .y_pos(y_pos), .pixel_out(pixel_out),
    .pixel_valid(pixel_valid), .frame_start(frame_start),
    .locked(locked), .err_count(err_count)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pixel clock of the reference raster; outputs read here reflect the previous edge
  task automatic tick();
    int len;
    @(negedge video_clk);
    if (idle) begin
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      pixel_in = 1'b0;
    end else begin
      hsync_in = !(!hold_h && gh < H_SYN);
      vsync_in = !(gv < V_SYN);
      pixel_in = pix_en && ((gh == HS && gv == VS) ||
                            (gh == HS + H_ACT - 1 && gv == VS + V_ACT - 1));
      len = (gv == short_v) ? H_TOT - 1 : H_TOT;
      gh++;
      if (gh == len) begin
        gh = 0;
        if (gv == short_v) short_v = -1;
        gv++;
        if (gv == frame_len) begin
          gv = 0;
          frame_len = V_TOT;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int hits, vcount;
    int hit_off [2];
    int hx [2];
    int hy [2];
    int hv [2];
    hits = 0;
    vcount = 0;
    for (int k = 0; k < 2; k++) begin
      hit_off[k] = -1; hx[k] = -1; hy[k] = -1; hv[k] = -1;
    end

    run(4);
    check_eq("reset_outputs", {x_pos, y_pos, pixel_out, pixel_valid, frame_start, locked, err_count}, 0);

    // Bn denotes the tick that drives the first clock of frame n
    reset = 1'b0;
    idle  = 1'b0;
    run(4);                       // B1+3
    check_eq("acq_b1_locked", locked, 0);
    run(FRAME);                   // B2+3
    check_eq("acq_b2_locked", locked, 0);
    run(FRAME - 1);               // B3+2
    check_eq("acq_b3_early", locked, 0);
    run(1);                       // B3+3
    check_eq("lock_b3", locked, 1);
    check_eq("fs_b3", frame_start, 1);
    check_eq("fs_b3_y", y_pos, 0);
    run(1);                       // B3+4
    check_eq("fs_b3_width", frame_start, 0);
    run(FRAME - 5);               // B4-1

    pix_en = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      tick();                     // B4+i
      if (i == 3) begin
        check_eq("fs_b4", frame_start, 1);
        check_eq("err_nominal", err_count, 0);
      end
      if (pixel_valid) vcount++;
      if (pixel_out) begin
        if (hits < 2) begin
          hit_off[hits] = i; hx[hits] = x_pos; hy[hits] = y_pos; hv[hits] = pixel_valid;
        end
        hits++;
      end
    end
    pix_en = 1'b0;
    check_eq("pix_hits", hits, 2);
    check_eq("pix0_time", hit_off[0], VS * H_TOT + HS + 3);
    check_eq("pix0_x", hx[0], 0);
    check_eq("pix0_y", hy[0], 0);
    check_eq("pix0_valid", hv[0], 1);
    check_eq("pix1_time", hit_off[1], (VS + V_ACT - 1) * H_TOT + HS + H_ACT - 1 + 3);
    check_eq("pix1_x", hx[1], H_ACT - 1);
    check_eq("pix1_y", hy[1], V_ACT - 1);
    check_eq("pix1_valid", hv[1], 1);
    check_eq("valid_count", vcount, H_ACT * V_ACT);

    // Line 9 of frame 5 is one clock short; line 10 hsync lands at offset 959
    short_v = 9;
    run(962);                     // B5+961
    check_eq("short_pre", locked, 1);
    run(1);                       // B5+962
    check_eq("short_unlock", locked, 0);
    check_eq("short_errcnt", err_count, 1);
    run(4799);                    // B8+2 (frame 5 is FRAME-1 long)
    check_eq("short_relock_early", locked, 0);
    run(1);                       // B8+3
    check_eq("short_relock", locked, 1);
    check_eq("short_relock_err", err_count, 1);

    // Frame 8 carries one line too few
    frame_len = V_TOT - 1;
    run((V_TOT - 1) * H_TOT - 1); // B9+2
    check_eq("vshort_pre", locked, 1);
    run(1);                       // B9+3
    check_eq("vshort_unlock", locked, 0);
    check_eq("vshort_errcnt", err_count, 2);
    check_eq("vshort_fs", frame_start, 0);
    run(3 * FRAME);               // B12+3
    check_eq("vshort_relock", locked, 1);

    // Loss of hsync; the last assertion at the pins was at B12
    run(10);                      // B12+13
    hold_h = 1'b1;
    run(181);                     // B12+194
    check_eq("los_pre", locked, 1);
    run(1);                       // B12+195
    check_eq("los_unlock", locked, 0);
    check_eq("los_errcnt", err_count, 3);
    run(700);                     // B12+895
    check_eq("los_no_repeat", err_count, 3);
    hold_h = 1'b0;
    run(FRAME + 3 - 895);         // B13+3
    check_eq("los_recover_err", err_count, 3);
    run(2 * FRAME);               // B15+3
    check_eq("los_relock", locked, 1);

    // Mid-frame reset while locked
    run(815);                     // B15+818: shows the pixel driven at line 8, column 47
    check_eq("mid_x", x_pos, 47 - HS);
    check_eq("mid_y", y_pos, 8 - VS);
    check_eq("mid_valid", pixel_valid, 1);
    reset = 1'b1;
    run(1);
    check_eq("midrst_outputs", {x_pos, y_pos, pixel_out, pixel_valid, frame_start, locked, err_count}, 0);
    run(2);                       // B15+821
    reset = 1'b0;
    run(3 * FRAME + 2 - 821);     // B18+2
    check_eq("rst_relock_early", locked, 0);
    run(1);                       // B18+3
    check_eq("rst_relock", locked, 1);
    check_eq("rst_relock_fs", frame_start, 1);
    check_eq("rst_relock_err", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
